// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition encodings and instruction field layout.
package cpu_pkg;

  typedef enum logic [1:0] {
    COND_AL = 2'd0,  // always execute
    COND_Z  = 2'd1,  // execute when zero flag set
    COND_NZ = 2'd2,  // execute when zero flag clear
    COND_C  = 2'd3   // execute when carry flag set
  } cond_e;

  typedef enum logic [2:0] {
    FLD_COND,
    FLD_OP,
    FLD_DEST,
    FLD_SRC1,
    FLD_SRC2,
    FLD_SHIFT
  } field_e;

  // LSB position of each field in an instruction laid out MSB-first as
  // cond | op_code | dest | src1 | src2 | shift.
  function automatic int field_lsb(input field_e f, input int op_w, input int reg_w);
    case (f)
      FLD_COND:  return 1 + 3 * reg_w + op_w;
      FLD_OP:    return 1 + 3 * reg_w;
      FLD_DEST:  return 1 + 2 * reg_w;
      FLD_SRC1:  return 1 + reg_w;
      FLD_SRC2:  return 1;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and data bundle around the decode stage.
interface decode_stage_if #(
  parameter int REG_W = 3,
  parameter int OP_W  = 4
);
  localparam int INST_W = 2 + OP_W + 3 * REG_W + 1;

  logic [INST_W-1:0] in_inst;
  logic              in_valid;
  logic              in_ready;
  logic              flag_z;
  logic              flag_c;
  logic              flush;
  logic [1:0]        out_cond;
  logic [OP_W-1:0]   out_op_code;
  logic [REG_W-1:0]  out_dest_reg;
  logic [REG_W-1:0]  out_src_reg_1;
  logic [REG_W-1:0]  out_src_reg_2;
  logic              out_shift;
  logic              out_illegal;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       squash_cnt;

  // Decode stage side.
  modport master (
    input  in_inst, in_valid, flag_z, flag_c, flush, out_ready,
    output in_ready, out_cond, out_op_code, out_dest_reg, out_src_reg_1,
           out_src_reg_2, out_shift, out_illegal, out_valid, squash_cnt
  );

  // Fetch / execute side.
  modport slave (
    output in_inst, in_valid, flag_z, flag_c, flush, out_ready,
    input  in_ready, out_cond, out_op_code, out_dest_reg, out_src_reg_1,
           out_src_reg_2, out_shift, out_illegal, out_valid, squash_cnt
  );
endinterface

// File: rtl/decode_fields.sv
// Combinational instruction slicer, shared with the existing decoder.
module decode_fields
  import cpu_pkg::*;
#(
  parameter  int REG_W  = 3,
  parameter  int OP_W   = 4,
  localparam int INST_W = 2 + OP_W + 3 * REG_W + 1
) (
  input  logic [INST_W-1:0] inst,
  output logic [1:0]        cond,
  output logic [OP_W-1:0]   op_code,
  output logic [REG_W-1:0]  dest_reg,
  output logic [REG_W-1:0]  src_reg_1,
  output logic [REG_W-1:0]  src_reg_2,
  output logic              shift
);
  localparam int COND_LSB  = field_lsb(FLD_COND, OP_W, REG_W);
  localparam int OP_LSB    = field_lsb(FLD_OP, OP_W, REG_W);
  localparam int DEST_LSB  = field_lsb(FLD_DEST, OP_W, REG_W);
  localparam int SRC1_LSB  = field_lsb(FLD_SRC1, OP_W, REG_W);
  localparam int SRC2_LSB  = field_lsb(FLD_SRC2, OP_W, REG_W);
  localparam int SHIFT_LSB = field_lsb(FLD_SHIFT, OP_W, REG_W);

  assign cond      = inst[COND_LSB +: 2];
  assign op_code   = inst[OP_LSB +: OP_W];
  assign dest_reg  = inst[DEST_LSB +: REG_W];
  assign src_reg_1 = inst[SRC1_LSB +: REG_W];
  assign src_reg_2 = inst[SRC2_LSB +: REG_W];
  assign shift     = inst[SHIFT_LSB];
endmodule

// File: rtl/decode_stage.sv
// Decode stage: slices instructions, drops condition-failed ones and holds
// passing ones in a 2-entry skid buffer with fully registered outputs.
module decode_stage
  import cpu_pkg::*;
#(
  parameter  int                     REG_W        = 3,
  parameter  int                     OP_W         = 4,
  parameter  logic [(2**OP_W)-1:0]   ILLEGAL_MASK = '0,
  localparam int                     INST_W       = 2 + OP_W + 3 * REG_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic              flush,
  output logic [1:0]        out_cond,
  output logic [OP_W-1:0]   out_op_code,
  output logic [REG_W-1:0]  out_dest_reg,
  output logic [REG_W-1:0]  out_src_reg_1,
  output logic [REG_W-1:0]  out_src_reg_2,
  output logic              out_shift,
  output logic              out_illegal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       squash_cnt
);
  typedef struct packed {
    logic [1:0]       cond;
    logic [OP_W-1:0]  op_code;
    logic [REG_W-1:0] dest_reg;
    logic [REG_W-1:0] src_reg_1;
    logic [REG_W-1:0] src_reg_2;
    logic             shift;
    logic             illegal;
  } entry_t;

  entry_t      new_entry;
  entry_t      head_q;       // oldest entry, drives the out_* ports directly
  entry_t      skid_q;       // second entry, only meaningful when count_q == 2
  logic [1:0]  count_q;
  logic [1:0]  count_n;
  logic        out_valid_q;
  logic        in_ready_q;
  logic [15:0] squash_q;
  logic        cond_pass;
  logic        accept;
  logic        push;
  logic        pop;

  decode_fields #(.REG_W(REG_W), .OP_W(OP_W)) u_fields (
    .inst      (in_inst),
    .cond      (new_entry.cond),
    .op_code   (new_entry.op_code),
    .dest_reg  (new_entry.dest_reg),
    .src_reg_1 (new_entry.src_reg_1),
    .src_reg_2 (new_entry.src_reg_2),
    .shift     (new_entry.shift)
  );

  assign new_entry.illegal = ILLEGAL_MASK[new_entry.op_code];

  // Evaluate the condition code against the flags of the accepting cycle.
  always_comb begin
    // NOTE: default first so no path through the case leaves cond_pass unassigned (latch).
    cond_pass = 1'b0;
    case (cond_e'(new_entry.cond))
      COND_AL: cond_pass = 1'b1;
      COND_Z:  cond_pass = flag_z;
      COND_NZ: cond_pass = !flag_z;
      COND_C:  cond_pass = flag_c;
      default: cond_pass = 1'b0;
    endcase
  end

  assign accept  = in_valid && in_ready_q;
  assign push    = accept && cond_pass && !flush;
  assign pop     = out_valid_q && out_ready;
  assign count_n = flush ? 2'd0 : (count_q - {1'b0, pop} + {1'b0, push});

  // Buffer occupancy, handshake flags, entry storage and squash counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      count_q     <= 2'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      squash_q    <= 16'd0;
      head_q      <= '0;
      // NOTE: the skid slot is cleared too; it is tiny and keeps reset state fully defined.
      skid_q      <= '0;
    end else begin
      count_q     <= count_n;
      out_valid_q <= (count_n != 2'd0);
      // After an accept with one entry left, a second accept could still arrive
      // while that entry stalls, so ready only reopens one cycle later.
      in_ready_q  <= (count_n == 2'd0) || ((count_n == 2'd1) && !accept);
      if (!flush) begin
        if (pop) begin
          if (count_q == 2'd2) head_q <= skid_q;
          else if (push)       head_q <= new_entry;
        end else if ((count_q == 2'd0) && push) begin
          head_q <= new_entry;
        end
        if (push && (((count_q == 2'd1) && !pop) || ((count_q == 2'd2) && pop)))
          skid_q <= new_entry;
        if (accept && !cond_pass && (squash_q != 16'hFFFF))
          squash_q <= squash_q + 16'd1;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign squash_cnt    = squash_q;
  assign out_cond      = head_q.cond;
  assign out_op_code   = head_q.op_code;
  assign out_dest_reg  = head_q.dest_reg;
  assign out_src_reg_1 = head_q.src_reg_1;
  assign out_src_reg_2 = head_q.src_reg_2;
  assign out_shift     = head_q.shift;
  assign out_illegal   = head_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.REG_W(3), .OP_W(4)) bus ();

  decode_stage #(.REG_W(3), .OP_W(4), .ILLEGAL_MASK(16'h8000)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_inst       (bus.in_inst),
    .in_valid      (bus.in_valid),
    .in_ready      (bus.in_ready),
    .flag_z        (bus.flag_z),
    .flag_c        (bus.flag_c),
    .flush         (bus.flush),
    .out_cond      (bus.out_cond),
    .out_op_code   (bus.out_op_code),
    .out_dest_reg  (bus.out_dest_reg),
    .out_src_reg_1 (bus.out_src_reg_1),
    .out_src_reg_2 (bus.out_src_reg_2),
    .out_shift     (bus.out_shift),
    .out_illegal   (bus.out_illegal),
    .out_valid     (bus.out_valid),
    .out_ready     (bus.out_ready),
    .squash_cnt    (bus.squash_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: held instructions in order, ready flag, squash count.
  logic [15:0] mq[$];
  logic        m_rdy = 1'b1;
  int          m_sq = 0;
  logic        m_acc = 1'b0;   // last offered instruction was accepted
  int          m_pops = 0;

  function automatic bit cond_ok(input logic [15:0] inst, input logic fz, input logic fc);
    case (int'(inst) / 16384)
      0:       return 1'b1;
      1:       return fz;
      2:       return !fz;
      default: return fc;
    endcase
  endfunction

  task automatic compare_outputs();
    int op;
    check("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    check("squash_cnt", 32'(bus.squash_cnt), 32'(m_sq));
    if (mq.size() != 0) begin
      op = (int'(mq[0]) / 1024) % 16;
      check("cond", 32'(bus.out_cond), 32'(int'(mq[0]) / 16384));
      check("op_code", 32'(bus.out_op_code), 32'(op));
      check("dest", 32'(bus.out_dest_reg), 32'((int'(mq[0]) / 128) % 8));
      check("src1", 32'(bus.out_src_reg_1), 32'((int'(mq[0]) / 16) % 8));
      check("src2", 32'(bus.out_src_reg_2), 32'((int'(mq[0]) / 2) % 8));
      check("shift", 32'(bus.out_shift), 32'(int'(mq[0]) % 2));
      check("illegal", 32'(bus.out_illegal), 32'(op == 15));
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic v, input logic [15:0] inst,
                      input logic fz, input logic fc, input logic fl, input logic ordy);
    bit popm;
    rst = r; bus.in_valid = v; bus.in_inst = inst;
    bus.flag_z = fz; bus.flag_c = fc; bus.flush = fl; bus.out_ready = ordy;
    @(negedge clk);
    compare_outputs();
    if (r) begin
      mq.delete(); m_rdy = 1'b1; m_sq = 0; m_acc = 1'b0;
    end else begin
      m_acc = v && m_rdy;
      popm  = (mq.size() != 0) && ordy;
      if (fl) mq.delete();
      else begin
        if (popm) begin
          void'(mq.pop_front());
          m_pops++;
        end
        if (m_acc) begin
          if (cond_ok(inst, fz, fc)) mq.push_back(inst);
          else if (m_sq < 65535) m_sq++;
        end
      end
      m_rdy = (mq.size() == 0) || ((mq.size() == 1) && !m_acc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, ordy);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_sq"}, 32'(bus.squash_cnt), 32'd0);
    check({tag, "_fields"}, 32'({bus.out_cond, bus.out_op_code, bus.out_dest_reg,
          bus.out_src_reg_1, bus.out_src_reg_2, bus.out_shift, bus.out_illegal}), 32'd0);
  endtask

  // Offer instructions with out_ready low until two are held.
  task automatic fill_two(input logic [15:0] base);
    int k = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, base + 16'(k * 3), 1'b0, 1'b0, 1'b0, 1'b0);
      if (m_acc) k++;
    end
  endtask

  initial begin
    int pops_before;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.flag_z = 1'b0;
    bus.flag_c = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");

    // Basic decode of a cond-always instruction.
    step(1'b0, 1'b1, 16'h2AAA, 1'b0, 1'b0, 1'b0, 1'b1);
    check("r027_valid", 32'(bus.out_valid), 32'd1);
    check("r027_op", 32'(bus.out_op_code), 32'd10);
    check("r027_dest", 32'(bus.out_dest_reg), 32'd5);
    check("r027_src1", 32'(bus.out_src_reg_1), 32'd2);
    check("r027_src2", 32'(bus.out_src_reg_2), 32'd5);
    check("r027_shift", 32'(bus.out_shift), 32'd0);
    idle(1'b1);

    // Zero-flag condition: squashed, then emitted.
    step(1'b0, 1'b1, 16'h6AAA, 1'b0, 1'b0, 1'b0, 1'b1);
    check("r028_squash_valid", 32'(bus.out_valid), 32'd0);
    check("r028_squash_cnt", 32'(bus.squash_cnt), 32'd1);
    step(1'b0, 1'b1, 16'h6AAA, 1'b1, 1'b0, 1'b0, 1'b1);
    check("r028_pass_valid", 32'(bus.out_valid), 32'd1);
    idle(1'b1);

    // Backpressure: two held, third held off, then in-order drain.
    fill_two(16'h0101);
    check("r029_ready", 32'(bus.in_ready), 32'd0);
    check("r029_valid", 32'(bus.out_valid), 32'd1);
    pops_before = m_pops;
    repeat (4) idle(1'b1);
    check("r029_drained", 32'(m_pops - pops_before), 32'd2);

    // Illegal opcode marking.
    step(1'b0, 1'b1, 16'h3C00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("r030_op15", 32'(bus.out_illegal), 32'd1);
    idle(1'b1);
    step(1'b0, 1'b1, 16'h3800, 1'b0, 1'b0, 1'b0, 1'b1);
    check("r030_op14", 32'(bus.out_illegal), 32'd0);
    idle(1'b1);

    // Flush with two held and an offered instruction.
    fill_two(16'h0203);
    step(1'b0, 1'b1, 16'h0444, 1'b0, 1'b0, 1'b1, 1'b0);
    check("r031_valid", 32'(bus.out_valid), 32'd0);
    check("r031_ready", 32'(bus.in_ready), 32'd1);
    // Flush with one held and a concurrent squash-worthy accept.
    step(1'b0, 1'b1, 16'h0555, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b1, 16'h6AAA, 1'b0, 1'b0, 1'b1, 1'b0);
    check("r031_valid2", 32'(bus.out_valid), 32'd0);
    check("r031_sq", 32'(bus.squash_cnt), 32'd1);
    idle(1'b1);

    // Reset in the middle of a stall.
    fill_two(16'h0707);
    step(1'b1, 1'b1, 16'h0999, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_state("r032");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 16'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) != 0);
    end
    repeat (3) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter REG_W, default 3, register-address width per field.
REQ-002 SHALL have parameter OP_W, default 4, opcode width.
REQ-003 SHALL have parameter ILLEGAL_MASK, default 16'h0000, one bit per opcode, 1 = opcode illegal; width 2**OP_W.
REQ-004 SHALL derive local INST_W = 2 + OP_W + 3*REG_W + 1 (default 16).
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: in_inst  in  INST_W  raw instruction; in_valid  in  1; in_ready  out  1.
REQ-007 SHALL have ports: flag_z  in  1  zero flag; flag_c  in  1  carry flag; flush  in  1  discard all held instructions.
REQ-008 SHALL have ports: out_cond  out  2; out_op_code  out  OP_W; out_dest_reg, out_src_reg_1, out_src_reg_2  out  REG_W each; out_shift  out  1.
REQ-009 SHALL have ports: out_illegal  out  1  opcode illegal; out_valid  out  1; out_ready  in  1.
REQ-010 SHALL have port squash_cnt  out  16  count of condition-failed instructions.

Function
REQ-011 SHALL slice in_inst MSB-first: cond[INST_W-1:INST_W-2], op_code next OP_W bits, then dest, src1, src2 (REG_W each), shift = bit 0.
REQ-012 SHALL accept an instruction on a cycle with in_valid && in_ready.
REQ-013 SHALL evaluate the condition on acceptance using same-cycle flags: cond 0 = always, 1 = flag_z, 2 = !flag_z, 3 = flag_c.
REQ-014 SHALL discard accepted instructions whose condition fails, never presenting them on the output, and increment squash_cnt by 1 (saturating at 16'hFFFF).
REQ-015 SHALL store passing instructions decoded, with out_illegal = ILLEGAL_MASK[op_code], in a 2-entry FIFO skid buffer.
REQ-016 SHALL present the oldest entry on the out_* ports with out_valid = 1 the cycle after acceptance (1-cycle latency), all outputs driven from registers.
REQ-017 SHALL pop the oldest entry on a cycle with out_valid && out_ready.
REQ-018 SHALL drive in_ready as a registered signal equal to 1 when 0 entries are held, or when 1 entry is held and no accept occurred in the previous cycle, so no accepted instruction is lost.
REQ-019 SHALL hold out_* stable while out_valid && !out_ready.
REQ-020 SHALL support simultaneous push and pop with 1 entry held: occupancy stays 1 and the new entry becomes the head next cycle.
REQ-021 SHALL, on flush, empty the buffer next cycle (out_valid = 0), ignore any same-cycle accept, and leave squash_cnt unchanged.
REQ-022 SHALL treat illegal opcodes as normal traffic except for setting out_illegal.

Reset
REQ-023 SHALL on rst clear occupancy, out_valid = 0, in_ready = 1, squash_cnt = 0, and all out_* data fields = 0.
REQ-024 SHALL give rst priority over flush, accept and pop, including mid-stall.

Structure
REQ-025 SHALL place the cond encodings (COND_AL, COND_Z, COND_NZ, COND_C) and the field-offset function in shared package cpu_pkg.
REQ-026 SHALL instantiate one sub-module, decode_fields, the combinational slicer, reused by the existing decoder.

Verification
REQ-027 Reset, then 16'h2AAA with cond 0, out_ready = 1 -> next cycle out_valid = 1, op_code = 10, dest = 5, src1 = 2, src2 = 5, shift = 0.
REQ-028 16'h6AAA with flag_z = 0 -> no out_valid, squash_cnt = 1; same with flag_z = 1 -> emitted.
REQ-029 out_ready = 0, push 3 back-to-back -> 2 held, in_ready = 0, third held off; release -> in-order output, none lost.
REQ-030 ILLEGAL_MASK = 16'h8000, opcode 15 -> out_illegal = 1; opcode 14 -> out_illegal = 0.
REQ-031 Flush with 2 held plus a concurrent accept -> out_valid = 0 next cycle, in_ready = 1, nothing emitted.
REQ-032 rst asserted during an out_ready stall -> all outputs at reset values next cycle.
